// File: rtl/mcinput_frame_decoder_pkg.sv
// Shared types and constants for the GBT RX frame decoder: the motor input record,
// its safe value, the frame marker and the link supervision states.
package mcinput_frame_decoder_pkg;

    typedef struct packed {
        logic       OH;
        logic       StepPFail;
        logic [1:0] RawSwitches_b2;
    } mcinput_t;

    localparam int NUM_MOTORS = 16;

    localparam logic [15:0] GEFE_INTERLOCK = 16'h92AC;
    localparam logic [15:0] FRAME_MARKER   = GEFE_INTERLOCK[15:0];

    // Both extremities active: any MC unit reading this blocks motion.
    localparam mcinput_t MCINPUT_SAFE = '{OH: 1'b1, StepPFail: 1'b1, RawSwitches_b2: 2'b11};

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } linkstate_t;

endpackage

// File: rtl/mcinput_debounce.sv
// One motor's input debouncer: tracks a candidate value across accepted frames and
// moves it to the output once it has been seen g_DebounceFrames times in a row.
module mcinput_debounce
    import mcinput_frame_decoder_pkg::*;
#(
    parameter int g_DebounceFrames = 3
) (
    input  logic       Clk_ik,
    input  logic       Rst_ir,
    input  logic [3:0] Field_i,
    input  logic       Accept_i,
    input  logic       Load_i,
    input  logic       Clear_i,
    output logic [3:0] Out_o,
    output logic       Changed_o
);

    localparam int              CW      = $clog2(g_DebounceFrames + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(g_DebounceFrames);

    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic [3:0]    out_q,  out_d;

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        Changed_o = 1'b0;
        if (Clear_i) begin
            cand_d = '0;
            cnt_d  = '0;
            out_d  = MCINPUT_SAFE;
        end else if (Load_i) begin
            // Link coming up: adopt the frame as-is, considered already stable.
            cand_d = Field_i;
            cnt_d  = CNT_MAX;
            out_d  = Field_i;
        end else if (Accept_i) begin
            if (Field_i == cand_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            end else begin
                cand_d = Field_i;
                cnt_d  = CW'(1);
            end
            if ((cnt_d == CNT_MAX) && (cand_d != out_q)) begin
                out_d     = cand_d;
                Changed_o = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_ik) begin
        if (Rst_ir) begin
            cand_q <= '0;
            cnt_q  <= '0;
            out_q  <= MCINPUT_SAFE;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign Out_o = out_q;

endmodule

// File: rtl/mcinput_frame_decoder.sv
// Receive-side GBT frame decoder: marker check, per-motor debounce, link watchdog FSM,
// sticky change flags with IRQ strobe, and frame/marker-error statistics.
module mcinput_frame_decoder
    import mcinput_frame_decoder_pkg::*;
#(
    parameter int g_DebounceFrames = 3,
    parameter int g_LinkTimeout    = 1024
) (
    input  logic                  Clk_ik,
    input  logic                  Rst_ir,
    input  logic [79:0]           RxFrame_ib80,
    input  logic                  RxValid_i,
    input  logic                  RxReady_i,
    input  logic [15:0]           ClearChange_i,
    output mcinput_t [15:0]       MotorInputs_ox,
    output logic [15:0]           ChangeFlags_ob16,
    output logic                  ChangeIrq_o,
    output logic                  LinkUp_o,
    output logic [15:0]           FrameCount_ob16,
    output logic [15:0]           MarkerErrors_ob16
);

    localparam int WDW = $clog2(g_LinkTimeout + 1);
    localparam int UPW = $clog2(g_DebounceFrames + 1);

    // Input capture stage: every decision is taken one cycle after the sampling edge.
    logic [63:0] frame_q;
    logic        acc_q;
    logic        mkerr_q;
    logic        ready_q;
    logic        marker_ok;

    assign marker_ok = (RxFrame_ib80[79:64] == FRAME_MARKER);

    always_ff @(posedge Clk_ik) begin
        if (Rst_ir) begin
            frame_q <= '0;
            acc_q   <= 1'b0;
            mkerr_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            frame_q <= RxFrame_ib80[63:0];
            acc_q   <= RxValid_i & RxReady_i & marker_ok;
            mkerr_q <= RxValid_i & RxReady_i & ~marker_ok;
            ready_q <= RxReady_i;
        end
    end

    linkstate_t     state_q, state_d;
    logic [WDW-1:0] wd_q,    wd_d;
    logic [UPW-1:0] upcnt_q, upcnt_d;
    logic [15:0]    flags_q, flags_d;
    logic           irq_q,   irq_d;
    logic [15:0]    fcnt_q,  fcnt_d;
    logic [15:0]    merr_q,  merr_d;
    logic           go_up, go_down, db_accept;
    logic [15:0]    changed;

    assign go_up   = (state_q == DOWN) && acc_q && (upcnt_q == UPW'(g_DebounceFrames - 1));
    // An accepted frame in the timeout cycle keeps the link alive.
    assign go_down = (state_q == UP) &&
                     (!ready_q || (!acc_q && (wd_q == WDW'(g_LinkTimeout))));
    assign db_accept = (state_q == UP) && acc_q && !go_down;

    always_comb begin
        state_d = state_q;
        upcnt_d = upcnt_q;
        wd_d    = '0;
        fcnt_d  = fcnt_q;
        merr_d  = merr_q;
        if (go_up) begin
            state_d = UP;
        end else if (go_down) begin
            state_d = DOWN;
        end
        if (state_q == DOWN) begin
            if (acc_q) begin
                upcnt_d = go_up ? '0 : upcnt_q + UPW'(1);
            end
        end else begin
            upcnt_d = '0;
            if (!go_down && !acc_q) begin
                wd_d = (wd_q == WDW'(g_LinkTimeout)) ? wd_q : wd_q + WDW'(1);
            end
        end
        if (acc_q) begin
            fcnt_d = fcnt_q + 16'd1;
        end
        if (mkerr_q && (merr_q != 16'hFFFF)) begin
            merr_d = merr_q + 16'd1;
        end
        flags_d = (flags_q & ~ClearChange_i) | changed;
        irq_d   = |(changed & ~flags_q);
    end

    always_ff @(posedge Clk_ik) begin
        if (Rst_ir) begin
            state_q <= DOWN;
            wd_q    <= '0;
            upcnt_q <= '0;
            flags_q <= '0;
            irq_q   <= 1'b0;
            fcnt_q  <= '0;
            merr_q  <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            upcnt_q <= upcnt_d;
            flags_q <= flags_d;
            irq_q   <= irq_d;
            fcnt_q  <= fcnt_d;
            merr_q  <= merr_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MOTORS; gi++) begin : g_motor
            logic [3:0] out_w;
            mcinput_debounce #(
                .g_DebounceFrames(g_DebounceFrames)
            ) u_debounce (
                .Clk_ik   (Clk_ik),
                .Rst_ir   (Rst_ir),
                .Field_i  (frame_q[4*gi +: 4]),
                .Accept_i (db_accept),
                .Load_i   (go_up),
                .Clear_i  (go_down),
                .Out_o    (out_w),
                .Changed_o(changed[gi])
            );
            assign MotorInputs_ox[gi] = mcinput_t'(out_w);
        end
    endgenerate

    assign ChangeFlags_ob16  = flags_q;
    assign ChangeIrq_o       = irq_q;
    assign LinkUp_o          = (state_q == UP);
    assign FrameCount_ob16   = fcnt_q;
    assign MarkerErrors_ob16 = merr_q;

endmodule
